// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and helpers for the two-requester shared-register arbiter.
//   State encodings, default hold limit, hold-counter width helper and the
//   round-robin pick used whenever the arbiter is free to choose.
package arb_pkg;

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_OWN0 = 2'b01;
  localparam logic [1:0] ARB_OWN1 = 2'b10;

  localparam int unsigned MAX_HOLD_DFLT = 4;

  // Counter width for a hold limit; at least one bit even for the smallest limit.
  function automatic int unsigned hold_w_f(input int unsigned max_hold);
    return (max_hold > 2) ? $clog2(max_hold) : 1;
  endfunction

  localparam int unsigned HOLD_W = hold_w_f(MAX_HOLD_DFLT);

  // Round-robin choice: on contention the requester that did not go last wins.
  function automatic logic [1:0] arb_pick(input logic r0, input logic r1, input logic last);
    logic [1:0] s;
    s = ARB_IDLE;
    if (r0 && r1)  s = last ? ARB_OWN0 : ARB_OWN1;
    else if (r0)   s = ARB_OWN0;
    else if (r1)   s = ARB_OWN1;
    return s;
  endfunction

endpackage

// File: rtl/arb2_shared_reg_if.sv
// arb2_shared_reg_if: request/grant/capture bundle between the two producers and the arbiter.
//   master: drives req0/1, lock0/1, data0/1; observes gnt0/1, sel, q, q_valid, q_src.
//   slave : the arbiter side (opposite directions).
interface arb2_shared_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic             lock0;
  logic             lock1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_src;

  modport master (
    output req0, req1, lock0, lock1, data0, data1,
    input  gnt0, gnt1, sel, q, q_valid, q_src
  );

  modport slave (
    input  req0, req1, lock0, lock1, data0, data1,
    output gnt0, gnt1, sel, q, q_valid, q_src
  );
endinterface

// File: rtl/arb2_shared_reg_cells.sv
// Leaf cells of the capture datapath.
//   mux2 : 1-bit 2:1 mux, a when s=0, b when s=1 (y_c combinational).
//   dff_r: W-bit flop, asynchronous active-low reset to zero.
module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y_c
);
  assign y_c = s ? b : a;
endmodule

module dff_r #(
  parameter int unsigned W = 1
) (
  input  logic         clock,
  input  logic         reset_l,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) q <= '0;
    else          q <= d;
  end
endmodule

// File: rtl/arb_hold_cnt.sv
// arb_hold_cnt: counts consecutive cycles in one ownership state, saturating at MAX_HOLD-1.
//   clock, reset_l : clock / async active-low reset
//   clr            : state is changing this cycle, restart from zero
//   en             : currently in an ownership state
//   term_c         : count has reached MAX_HOLD-1
module arb_hold_cnt
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DFLT
) (
  input  logic clock,
  input  logic reset_l,
  input  logic clr,
  input  logic en,
  output logic term_c
);
  localparam int unsigned CNT_W = hold_w_f(MAX_HOLD);
  localparam int unsigned SAT   = MAX_HOLD - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating increment with priority clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                             cnt_d = '0;
    else if (en && cnt_q != CNT_W'(SAT)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign term_c = (cnt_q == CNT_W'(SAT));
endmodule

// File: rtl/arb2_shared_reg.sv
// arb2_shared_reg: two-requester round-robin arbiter with lock, driving the select of a
// shared WIDTH-bit capture register and presenting captured data with a one-cycle valid.
//   clock, reset_l : clock / async active-low reset
//   bus (slave)    : req/lock/data from the producers; gnt/sel/q/q_valid/q_src back
// Optional feature: define ARB_TIMEOUT_EN to force a locked owner to release after
// MAX_HOLD consecutive cycles while the other requester waits.
module arb2_shared_reg
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DFLT
) (
  input  logic                 clock,
  input  logic                 reset_l,
  arb2_shared_reg_if.slave     bus
);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             hold_term_c;
  logic             force_sw_c;
  logic             xfer_c;
  logic [WIDTH-1:0] mux_y_c;
  logic [WIDTH-1:0] q_r, q_d;
  logic             q_valid_r, q_valid_d;
  logic             q_src_r, q_src_d;

  // Keeps configuration constants referenced in every build.
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_HOLD), 32'(HOLD_W)};

`ifdef ARB_TIMEOUT_EN
  arb_hold_cnt #(.MAX_HOLD(MAX_HOLD)) u_hold_cnt (
    .clock   (clock),
    .reset_l (reset_l),
    .clr     (state_d != state_q),
    .en      (state_q != ARB_IDLE),
    .term_c  (hold_term_c)
  );
`else
  assign hold_term_c = 1'b0;
`endif

  // Timeout release only when the other side is actually waiting.
  assign force_sw_c = hold_term_c &&
                      (((state_q == ARB_OWN0) && bus.req1) ||
                       ((state_q == ARB_OWN1) && bus.req0));

  // Next state; leaving an ownership state arbitrates as if that owner went last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_OWN0: begin
        if (force_sw_c)                state_d = ARB_OWN1;
        else if (bus.req0 && bus.lock0) state_d = ARB_OWN0;
        else                           state_d = arb_pick(bus.req0, bus.req1, 1'b0);
      end
      ARB_OWN1: begin
        if (force_sw_c)                state_d = ARB_OWN0;
        else if (bus.req1 && bus.lock1) state_d = ARB_OWN1;
        else                           state_d = arb_pick(bus.req0, bus.req1, 1'b1);
      end
      default: state_d = arb_pick(bus.req0, bus.req1, last_q);
    endcase
    gnt0_d = (state_d == ARB_OWN0);
    gnt1_d = (state_d == ARB_OWN1);
  end

  // A transfer is a granted cycle whose owner is still requesting.
  assign xfer_c = (gnt0_q && bus.req0) || (gnt1_q && bus.req1);

  always_comb begin
    last_d    = xfer_c ? gnt1_q : last_q;
    q_d       = xfer_c ? mux_y_c : q_r;
    q_src_d   = xfer_c ? gnt1_q : q_src_r;
    q_valid_d = xfer_c;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  // Per-bit write-port select of the shared register.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux2 u_mux2 (
      .a   (bus.data0[i]),
      .b   (bus.data1[i]),
      .s   (gnt1_q),
      .y_c (mux_y_c[i])
    );
  end

  dff_r #(.W(WIDTH)) u_q_reg (
    .clock (clock), .reset_l (reset_l), .d (q_d), .q (q_r)
  );
  dff_r #(.W(1)) u_q_valid_reg (
    .clock (clock), .reset_l (reset_l), .d (q_valid_d), .q (q_valid_r)
  );
  dff_r #(.W(1)) u_q_src_reg (
    .clock (clock), .reset_l (reset_l), .d (q_src_d), .q (q_src_r)
  );

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.sel     = gnt1_q;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.q_src   = q_src_r;

endmodule
